// File: rtl/axi_write_master_pkg.sv
// Shared definitions for the single-beat AXI write master and its sort-controller client.
// Holds the FSM state encoding and the write-response codes.
package axi_write_master_pkg;

    // FSM encoding; all four codes are used, but the FSM still returns any
    // unknown value to idle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_WAIT_B = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Write-response codes as seen by the sort controller.
    localparam logic RESP_OK  = 1'b1;
    localparam logic RESP_ERR = 1'b0;

endpackage

// File: rtl/wr_timeout_counter.sv
// Per-transaction cycle counter for the AXI write master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : restart the count at zero (start of a transaction)
//   enable_i   : count this cycle (transaction in flight)
//   expired_o  : high in the enabled cycle that brings the count up to TIMEOUT_CYCLES
// TIMEOUT_CYCLES must be at least 1.
module wr_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_WDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WDTH-1:0] CNT_MAX  = CNT_WDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WDTH-1:0] CNT_LAST = CNT_WDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WDTH-1:0] count_q, count_d;

    // Expiry is flagged in the cycle whose increment reaches the limit, so the
    // owner leaves after exactly TIMEOUT_CYCLES counted cycles.
    always_comb begin
        expired_o = enable_i && (count_q >= CNT_LAST);
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_write_master.sv
// Single-beat AXI write master: takes one address/data pair from the sort
// controller, drives the AW and W channels, waits for B, and reports the result.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   start_i, wr_addr_i, wr_data_i  : request; address/data latched when start is accepted
//   done_o                         : one-cycle completion pulse (OK, error or timeout)
//   b_resp_o, timed_out_o          : result of the last transaction, held until next start
//   busy_o                         : high whenever not idle
//   aw_* / w_* / b_*               : AXI write address, data and response channels
module axi_write_master
    import axi_write_master_pkg::*;
#(
    parameter int unsigned ADDR_WDTH      = 4,
    parameter int unsigned DATA_WDTH      = 32,
    parameter int unsigned RESP_WDTH      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [ADDR_WDTH-1:0] wr_addr_i,
    input  logic [DATA_WDTH-1:0] wr_data_i,
    output logic                 done_o,
    output logic [RESP_WDTH-1:0] b_resp_o,
    output logic                 timed_out_o,
    output logic                 busy_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic [ADDR_WDTH-1:0] aw_addr_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [DATA_WDTH-1:0] w_data_o,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [RESP_WDTH-1:0] b_resp_in_i
);

    logic [1:0]           state_q, state_d;
    logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WDTH-1:0] w_data_q, w_data_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;
    logic                 timed_out_q, timed_out_d;

    logic                 aw_hs, w_hs;
    logic                 cnt_clear, cnt_enable, cnt_expired;

    // Channel controls are decoded straight from state and the done flags.
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        aw_valid_o  = (state_q == ST_SEND) && !aw_done_q;
        w_valid_o   = (state_q == ST_SEND) && !w_done_q;
        b_ready_o   = (state_q == ST_WAIT_B);
        done_o      = (state_q == ST_RESP);
        aw_addr_o   = aw_addr_q;
        w_data_o    = w_data_q;
        b_resp_o    = b_resp_q;
        timed_out_o = timed_out_q;
        aw_hs       = aw_valid_o && aw_ready_i;
        w_hs        = w_valid_o && w_ready_i;
        cnt_clear   = (state_q == ST_IDLE) && start_i;
        cnt_enable  = (state_q == ST_SEND) || (state_q == ST_WAIT_B);
    end

    wr_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .expired_o(cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_resp_d    = b_resp_q;
        timed_out_d = timed_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    aw_addr_d   = wr_addr_i;
                    w_data_d    = wr_data_i;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    b_resp_d    = '0;
                    timed_out_d = 1'b0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                // Finishing the address/data phase on the expiry cycle is not a
                // completed transaction, so the timeout wins here.
                if (cnt_expired) begin
                    b_resp_d    = {RESP_WDTH{RESP_ERR}};
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (aw_done_d && w_done_d) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                // A response arriving on the expiry cycle still counts as normal.
                if (b_valid_i) begin
                    b_resp_d = b_resp_in_i;
                    state_d  = ST_RESP;
                end else if (cnt_expired) begin
                    b_resp_d    = {RESP_WDTH{RESP_ERR}};
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_resp_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_resp_q    <= b_resp_d;
            timed_out_q <= timed_out_d;
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: stimulus pushes the expected result of
// each request; a negedge monitor pops and compares on every done pulse.
module tb_axi_write_master;
    import axi_write_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        done;
    logic [0:0]  b_resp;
    logic        timed_out;
    logic        busy;
    logic        aw_valid;
    logic        aw_ready = 1'b0;
    logic [3:0]  aw_addr;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [31:0] w_data;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [0:0]  b_resp_in = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        resp;
        logic        to;
        int          done_cyc;
        int          aw_hs;
        int          w_hs;
        int          aw_cyc;
        int          w_cyc;
    } exp_t;

    exp_t sb_q[$];

    axi_write_master #(
        .ADDR_WDTH     (4),
        .DATA_WDTH     (32),
        .RESP_WDTH     (1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .done_o     (done),
        .b_resp_o   (b_resp),
        .timed_out_o(timed_out),
        .busy_o     (busy),
        .aw_valid_o (aw_valid),
        .aw_ready_i (aw_ready),
        .aw_addr_o  (aw_addr),
        .w_valid_o  (w_valid),
        .w_ready_i  (w_ready),
        .w_data_o   (w_data),
        .b_valid_i  (b_valid),
        .b_ready_o  (b_ready),
        .b_resp_in_i(b_resp_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake bookkeeping, scoreboard pop on done, held-result checks.
    initial begin : monitor
        int   aw_hs_cnt;
        int   w_hs_cnt;
        int   aw_cyc_cnt;
        int   w_cyc_cnt;
        bit   held_valid;
        logic held_resp;
        logic held_to;
        exp_t e;
        aw_hs_cnt = 0; w_hs_cnt = 0; aw_cyc_cnt = 0; w_cyc_cnt = 0;
        held_valid = 0; held_resp = 0; held_to = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_hs_cnt = 0; w_hs_cnt = 0; aw_cyc_cnt = 0; w_cyc_cnt = 0;
                held_valid = 0;
            end else begin
                if (aw_valid) aw_cyc_cnt++;
                if (w_valid) w_cyc_cnt++;
                if (aw_valid && aw_ready) aw_hs_cnt++;
                if (w_valid && w_ready) w_hs_cnt++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("b_resp", b_resp, e.resp);
                        chk("timed_out", timed_out, e.to);
                        chk("aw_addr", aw_addr, e.addr);
                        chk("w_data", w_data, e.data);
                        chk("busy_in_resp", busy, 1);
                        chk("aw_handshakes", aw_hs_cnt, e.aw_hs);
                        chk("w_handshakes", w_hs_cnt, e.w_hs);
                        chk("aw_valid_cycles", aw_cyc_cnt, e.aw_cyc);
                        chk("w_valid_cycles", w_cyc_cnt, e.w_cyc);
                        held_valid = 1;
                        held_resp  = e.resp;
                        held_to    = e.to;
                    end
                    aw_hs_cnt = 0; w_hs_cnt = 0; aw_cyc_cnt = 0; w_cyc_cnt = 0;
                end else if (!busy && held_valid) begin
                    chk("held_b_resp", b_resp, held_resp);
                    chk("held_timed_out", timed_out, held_to);
                    chk("idle_aw_valid", aw_valid, 0);
                    chk("idle_w_valid", w_valid, 0);
                    chk("idle_b_ready", b_ready, 0);
                end
            end
        end
    end

    // aw_d/w_d: SEND cycles with ready low; b_k: b_valid high from cycle N+b_k on.
    // glitch: pulse start with a different address through cycles N+1..N+3.
    task automatic run_txn(input logic [3:0] a, input logic [31:0] d,
                           input int aw_d, input int w_d, input int b_k, input logic rin,
                           input int lat, input logic e_resp, input logic e_to,
                           input int e_aw_hs, input int e_w_hs,
                           input int e_aw_cyc, input int e_w_cyc, input bit glitch);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; wr_addr = a; wr_data = d; b_resp_in = rin;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
        e.addr = a; e.data = d; e.resp = e_resp; e.to = e_to; e.done_cyc = cyc + lat;
        e.aw_hs = e_aw_hs; e.w_hs = e_w_hs; e.aw_cyc = e_aw_cyc; e.w_cyc = e_w_cyc;
        sb_q.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            start = glitch && (k <= 3);
            if (glitch) begin
                wr_addr = 4'hF;
                wr_data = 32'hFFFF_FFFF;
            end
            aw_ready = (k > aw_d);
            w_ready  = (k > w_d);
            b_valid  = (k >= b_k);
        end
        @(posedge clk); #1;
        start = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_aw_addr", aw_addr, 0);
        chk("rst_w_data", w_data, 0);

        // Minimum latency, OK response.
        run_txn(4'h3, 32'hDEAD_BEEF, 0, 0, 2, RESP_OK, 3, RESP_OK, 0, 1, 1, 1, 1, 0);
        // AW ready delayed 3 cycles, W immediate; early b_valid must be ignored.
        run_txn(4'h5, 32'h1234_5678, 3, 0, 1, RESP_OK, 6, RESP_OK, 0, 1, 1, 4, 1, 0);
        // Error response held until next start.
        run_txn(4'hA, 32'hCAFE_0001, 0, 0, 2, RESP_ERR, 3, RESP_ERR, 0, 1, 1, 1, 1, 0);
        // W ready delayed 2 cycles, late b_valid.
        run_txn(4'h1, 32'h0BAD_F00D, 0, 2, 5, RESP_OK, 6, RESP_OK, 0, 1, 1, 1, 3, 0);
        // Timeout in SEND with aw_ready stuck low.
        run_txn(4'h7, 32'h55AA_55AA, 99, 0, 99, RESP_OK, 9, RESP_ERR, 1, 0, 1, 8, 1, 0);
        // Start pulsed in SEND/WAIT_B/RESP is ignored, then a normal request.
        run_txn(4'h2, 32'h0102_0304, 0, 0, 2, RESP_OK, 3, RESP_OK, 0, 1, 1, 1, 1, 1);
        run_txn(4'h9, 32'h1357_9BDF, 0, 0, 2, RESP_OK, 3, RESP_OK, 0, 1, 1, 1, 1, 0);
        // b_valid on the expiry cycle wins over the timeout.
        run_txn(4'h4, 32'hA5A5_A5A5, 0, 0, 8, RESP_OK, 9, RESP_OK, 0, 1, 1, 1, 1, 0);
        // Timeout in WAIT_B.
        run_txn(4'h6, 32'h0F0F_0F0F, 0, 0, 99, RESP_OK, 9, RESP_ERR, 1, 1, 1, 1, 1, 0);

        // Reset in WAIT_B: asynchronous return to reset values, no done.
        @(posedge clk); #1;
        start = 1'b1; wr_addr = 4'hC; wr_data = 32'h1111_2222;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; b_resp_in = RESP_OK;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("waitb_b_ready", b_ready, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_aw_valid", aw_valid, 0);
        chk("arst_w_valid", w_valid, 0);
        chk("arst_b_ready", b_ready, 0);
        chk("arst_timed_out", timed_out, 0);
        chk("arst_b_resp", b_resp, 0);
        chk("arst_aw_addr", aw_addr, 0);
        chk("arst_w_data", w_data, 0);
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        @(posedge clk); #1;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
        // Normal request after reset release, both readies one cycle late.
        run_txn(4'h8, 32'h8765_4321, 1, 1, 3, RESP_OK, 4, RESP_OK, 0, 1, 1, 2, 2, 0);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
